// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the CPU mem_cmd/mem_addr bus. Holds the 256x16
//   data/instruction RAM plus a small memory-mapped I/O decode (LED register
//   at LED_ADDR, switch input at SW_ADDR). Read data is registered: an MREAD
//   sampled at a posedge is visible on read_data for the whole next cycle.
//
// Optional feature (compile-time macro MEM_CLEAR_EN):
//   defined   -> every reset is followed by a 256-cycle CLEAR sweep that
//                zeroes the RAM; busy is high during the sweep.
//   undefined -> no sweep, busy tied low, RAM keeps its contents across reset.
//
// Ports:
//   clk         in   system clock, everything on posedge
//   reset       in   synchronous, active-low (0 = reset)
//   mem_cmd     in   2'b00 MNONE, 2'b01 MREAD, 2'b10 MWRITE, 2'b11 illegal
//   mem_addr    in   ADDR_W word address
//   write_data  in   DATA_W data for MWRITE
//   sw          in   8 switch inputs (read at SW_ADDR)
//   read_data   out  DATA_W registered read result
//   leds        out  8-bit LED register (written at LED_ADDR)
//   busy        out  high while the clear sweep runs
//   err         out  sticky flag: illegal command or unmapped access
//   dbg_state_o out  current FSM state (0 = SERVE, 1 = CLEAR)
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 16,
  parameter int                RAM_AW   = 8,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [7:0]        sw,
  output logic [DATA_W-1:0] read_data,
  output logic [7:0]        leds,
  output logic              busy,
  output logic              err,
  output logic              dbg_state_o
);

  // Command protocol: there is no handshake. mem_cmd/mem_addr/write_data are
  // sampled at every posedge and one command completes per cycle in SERVE.
  // While busy is high the sampled command is discarded without side effects.

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic {
    ST_SERVE = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] read_data_q;
  logic [7:0]        leds_q;
  logic              err_q;
`ifdef MEM_CLEAR_EN
  logic [RAM_AW-1:0] clr_ptr_q;
`endif

  logic [DATA_W-1:0] ram [0:(1<<RAM_AW)-1];

  // Address decode
  logic              is_ram;
  logic              is_led;
  logic              is_sw;
  logic [RAM_AW-1:0] ram_idx;

  // RAM write port, shared by the clear sweep and MWRITE
  logic              ram_we;
  logic [RAM_AW-1:0] ram_wa;
  logic [DATA_W-1:0] ram_wd;

  always_comb begin
    is_ram  = ~mem_addr[ADDR_W-1];
    is_led  = (mem_addr == LED_ADDR);
    is_sw   = (mem_addr == SW_ADDR);
    ram_idx = mem_addr[RAM_AW-1:0];
  end

  always_comb begin
    ram_we = 1'b0;
    ram_wa = ram_idx;
    ram_wd = write_data;
    // Reset gates the write port so a reset cycle never disturbs the RAM.
    if (reset) begin
`ifdef MEM_CLEAR_EN
      if (state_q == ST_CLEAR) begin
        ram_we = 1'b1;
        ram_wa = clr_ptr_q;
        ram_wd = '0;
      end else
`endif
      if (state_q == ST_SERVE && mem_cmd == MWRITE && is_ram) begin
        ram_we = 1'b1;
      end
    end
  end

  // RAM array carries no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_wa] <= ram_wd;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      read_data_q <= '0;
      leds_q      <= '0;
      err_q       <= 1'b0;
`ifdef MEM_CLEAR_EN
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
`else
      state_q     <= ST_SERVE;
`endif
    end else begin
      case (state_q)
        ST_CLEAR: begin
`ifdef MEM_CLEAR_EN
          // The last location is written in the same cycle we leave CLEAR.
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (clr_ptr_q == '1) begin
            state_q <= ST_SERVE;
          end
`else
          state_q <= ST_SERVE;
`endif
        end
        default: begin
          case (mem_cmd)
            MNONE: ;
            MREAD: begin
              if (is_ram) begin
                read_data_q <= ram[ram_idx];
              end else if (is_sw) begin
                read_data_q <= DATA_W'(sw);
              end else begin
                // LED is write-only, so reading it counts as unmapped.
                read_data_q <= '0;
                err_q       <= 1'b1;
              end
            end
            MWRITE: begin
              if (is_led) begin
                leds_q <= write_data[7:0];
              end else if (!is_ram) begin
                // SW is read-only; RAM writes go through the write port.
                err_q <= 1'b1;
              end
            end
            default: err_q <= 1'b1;
          endcase
        end
      endcase
    end
  end

  assign read_data   = read_data_q;
  assign leds        = leds_q;
  assign err         = err_q;
  assign dbg_state_o = (state_q == ST_CLEAR);
`ifdef MEM_CLEAR_EN
  assign busy        = (state_q == ST_CLEAR);
`else
  assign busy        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Self-checking bench for mem_responder. A directed table of
//   {reset, command, inputs, expected outputs} records, hand-written sequences
//   for the clear sweep / reset corner cases, and a randomized phase checked
//   against a behavioural memory model (arrays + expected-read queue).
//   Works in both builds: with and without MEM_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam logic [8:0] LED_A = 9'h100;
  localparam logic [8:0] SW_A  = 9'h140;
`ifdef MEM_CLEAR_EN
  localparam int CLR_CYC = 256;
`else
  localparam int CLR_CYC = 0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [7:0]  sw;
  logic [15:0] read_data;
  logic [7:0]  leds;
  logic        busy;
  logic        err;
  logic        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model
  logic [15:0] exp_q[$];
  logic [15:0] m_ram [256];
  bit          m_valid [256];
  logic [15:0] m_rd;
  logic [7:0]  m_leds;
  bit          m_err;

  mem_responder dut (
    .clk         (clk),
    .reset       (reset),
    .mem_cmd     (mem_cmd),
    .mem_addr    (mem_addr),
    .write_data  (write_data),
    .sw          (sw),
    .read_data   (read_data),
    .leds        (leds),
    .busy        (busy),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rd   = '0;
    m_leds = '0;
    m_err  = 1'b0;
    exp_q.delete();
`ifdef MEM_CLEAR_EN
    for (int i = 0; i < 256; i++) begin
      m_ram[i]   = '0;
      m_valid[i] = 1'b1;
    end
`endif
  endtask

  task automatic model_step(input logic [1:0] c, input logic [8:0] a,
                            input logic [15:0] d, input logic [7:0] s);
    case (c)
      2'b01: begin
        if (a < 9'd256) exp_q.push_back(m_ram[a[7:0]]);
        else if (a == SW_A) exp_q.push_back({8'h00, s});
        else begin
          exp_q.push_back(16'h0000);
          m_err = 1'b1;
        end
      end
      2'b10: begin
        if (a < 9'd256) begin
          m_ram[a[7:0]]   = d;
          m_valid[a[7:0]] = 1'b1;
        end else if (a == LED_A) m_leds = d[7:0];
        else m_err = 1'b1;
      end
      2'b11: m_err = 1'b1;
      default: ;
    endcase
  endtask

  // Driver: called at a negedge; command is sampled at the next posedge and
  // the following negedge is where the caller compares outputs.
  task automatic step(input logic [1:0] c, input logic [8:0] a,
                      input logic [15:0] d, input logic [7:0] s);
    mem_cmd    = c;
    mem_addr   = a;
    write_data = d;
    sw         = s;
    model_step(c, a, d, s);
    @(negedge clk);
    mem_cmd = 2'b00;
    if (exp_q.size() > 0) m_rd = exp_q.pop_front();
  endtask

  // Pulse reset for one posedge, then count cycles with busy high (bounded).
  task automatic do_reset(output int busy_cycles);
    mem_cmd = 2'b00;
    reset   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 2000) begin
      @(negedge clk);
      busy_cycles++;
    end
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          rst;
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
    logic [7:0]  swv;
    logic [15:0] e_rd;
    logic [7:0]  e_leds;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(bit r, logic [1:0] c, logic [8:0] a, logic [15:0] d,
                              logic [7:0] s, logic [15:0] erd, logic [7:0] el, logic ee);
    vec_t v;
    v.rst = r; v.cmd = c; v.addr = a; v.wd = d; v.swv = s;
    v.e_rd = erd; v.e_leds = el; v.e_err = ee;
    return v;
  endfunction

  initial begin
    vec_t        tbl[$];
    int          bc;
    logic [1:0]  c;
    logic [8:0]  a;
    logic [15:0] d;
    logic [7:0]  s;

    reset = 1'b0; mem_cmd = 2'b00; mem_addr = '0; write_data = '0; sw = '0;
    for (int i = 0; i < 256; i++) begin
      m_ram[i]   = '0;
      m_valid[i] = 1'b0;
    end
    @(negedge clk);

    //              rst cmd   addr    wdata     sw     rd        leds   err
    tbl.push_back(mk(1, 2'b00, 9'h000, 16'h0000, 8'h00, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 2'b10, 9'h012, 16'h1234, 8'h00, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 2'b01, 9'h012, 16'h0000, 8'h00, 16'h1234, 8'h00, 0));
    tbl.push_back(mk(0, 2'b00, 9'h012, 16'h0000, 8'h00, 16'h1234, 8'h00, 0));
    tbl.push_back(mk(0, 2'b10, LED_A,  16'hFFA5, 8'h00, 16'h1234, 8'hA5, 0));
    tbl.push_back(mk(0, 2'b01, SW_A,   16'h0000, 8'h3C, 16'h003C, 8'hA5, 0));
    tbl.push_back(mk(0, 2'b10, 9'h013, 16'h00FF, 8'h3C, 16'h003C, 8'hA5, 0));
    tbl.push_back(mk(0, 2'b01, 9'h013, 16'h0000, 8'h3C, 16'h00FF, 8'hA5, 0));
    tbl.push_back(mk(0, 2'b01, 9'h012, 16'h0000, 8'h3C, 16'h1234, 8'hA5, 0));
    tbl.push_back(mk(0, 2'b01, 9'h1FF, 16'h0000, 8'h3C, 16'h0000, 8'hA5, 1));
    tbl.push_back(mk(0, 2'b01, 9'h012, 16'h0000, 8'h3C, 16'h1234, 8'hA5, 1));
    tbl.push_back(mk(0, 2'b10, LED_A,  16'h0042, 8'h3C, 16'h1234, 8'h42, 1));
    tbl.push_back(mk(1, 2'b00, 9'h000, 16'h0000, 8'h00, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 2'b10, 9'h010, 16'h7777, 8'h00, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 2'b11, 9'h010, 16'h5555, 8'h00, 16'h0000, 8'h00, 1));
    tbl.push_back(mk(0, 2'b01, 9'h010, 16'h0000, 8'h00, 16'h7777, 8'h00, 1));
    tbl.push_back(mk(1, 2'b00, 9'h000, 16'h0000, 8'h00, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 2'b10, SW_A,   16'h1111, 8'h00, 16'h0000, 8'h00, 1));
    tbl.push_back(mk(1, 2'b00, 9'h000, 16'h0000, 8'h00, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 2'b10, 9'h1C0, 16'h9999, 8'h00, 16'h0000, 8'h00, 1));
    tbl.push_back(mk(1, 2'b00, 9'h000, 16'h0000, 8'h00, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 2'b10, 9'h020, 16'hABCD, 8'h00, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 2'b01, 9'h020, 16'h0000, 8'h00, 16'hABCD, 8'h00, 0));
    tbl.push_back(mk(0, 2'b01, LED_A,  16'h0000, 8'h00, 16'h0000, 8'h00, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        sw = tbl[i].swv;
        do_reset(bc);
        check($sformatf("tbl%0d_busy_cycles", i), 16'(bc), 16'(CLR_CYC));
      end else begin
        step(tbl[i].cmd, tbl[i].addr, tbl[i].wd, tbl[i].swv);
      end
      check($sformatf("tbl%0d_read_data", i), read_data, tbl[i].e_rd);
      check($sformatf("tbl%0d_leds", i), {8'h00, leds}, {8'h00, tbl[i].e_leds});
      check($sformatf("tbl%0d_err", i), {15'h0, err}, {15'h0, tbl[i].e_err});
    end

    // ---- reset effect on RAM: cleared with the sweep, retained without ----
    step(2'b10, 9'h005, 16'hBEEF, 8'h00);
    step(2'b01, 9'h005, 16'h0000, 8'h00);
    check("pre_reset_read_005", read_data, 16'hBEEF);
    do_reset(bc);
    check("reset_busy_cycles", 16'(bc), 16'(CLR_CYC));
    step(2'b01, 9'h005, 16'h0000, 8'h00);
`ifdef MEM_CLEAR_EN
    check("post_reset_read_005", read_data, 16'h0000);
`else
    check("post_reset_read_005", read_data, 16'hBEEF);
`endif

`ifdef MEM_CLEAR_EN
    // ---- commands during busy are ignored ----
    step(2'b10, 9'h030, 16'h2468, 8'h00);
    step(2'b01, 9'h030, 16'h0000, 8'h00);
    check("pre_busy_read_030", read_data, 16'h2468);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bc = 0;
    while (busy === 1'b1 && bc < 2000) begin
      mem_cmd = 2'b00;
      if (bc == 220) begin
        mem_cmd = 2'b10; mem_addr = 9'h030; write_data = 16'h1357;
      end else if (bc == 221) begin
        mem_cmd = 2'b11; mem_addr = 9'h010; write_data = 16'h5555;
      end else if (bc == 222) begin
        mem_cmd = 2'b01; mem_addr = 9'h1FF;
      end else if (bc == 224) begin
        check("busy_read_data_held", read_data, 16'h0000);
        check("busy_err_unaffected", {15'h0, err}, 16'h0000);
      end
      @(negedge clk);
      bc++;
    end
    mem_cmd = 2'b00;
    check("busy_ignore_cycles", 16'(bc), 16'd256);
    model_reset();
    step(2'b01, 9'h030, 16'h0000, 8'h00);
    check("busy_write_ignored_030", read_data, 16'h0000);
    step(2'b01, 9'h010, 16'h0000, 8'h00);
    check("busy_illegal_ignored_010", read_data, 16'h0000);
    check("busy_err_after", {15'h0, err}, 16'h0000);

    // ---- reset in the middle of the sweep restarts it ----
    do_reset(bc);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 100; k++) @(negedge clk);
    check("mid_sweep_busy_at_100", {15'h0, busy}, 16'h0001);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bc = 0;
    while (busy === 1'b1 && bc < 2000) begin
      @(negedge clk);
      bc++;
    end
    check("mid_sweep_restart_cycles", 16'(bc), 16'd256);
    model_reset();
`else
    // ---- without the sweep the first post-reset cycle is serviced ----
    do_reset(bc);
    check("no_clear_busy_low", {15'h0, busy}, 16'h0000);
    step(2'b10, 9'h0A0, 16'hC0DE, 8'h00);
    step(2'b01, 9'h0A0, 16'h0000, 8'h00);
    check("no_clear_first_cycle_rw", read_data, 16'hC0DE);
    do_reset(bc);
`endif

    // ---- randomized phase against the behavioural model ----
    for (int i = 0; i < 400; i++) begin
      bit allow_err;
      int k;
      int r;
      allow_err = (i >= 250);
      k = $urandom_range(0, 99);
      d = 16'($urandom);
      s = 8'($urandom);
      r = $urandom_range(0, 99);
      if (r < 60)      a = {1'b0, 8'($urandom_range(0, 31))};
      else if (r < 80) a = {1'b0, 8'($urandom_range(0, 255))};
      else if (r < 88) a = LED_A;
      else if (r < 96) a = SW_A;
      else             a = 9'h180 + 9'($urandom_range(0, 127));
      if (k < 8)       c = 2'b00;
      else if (k < 50) c = 2'b01;
      else             c = 2'b10;
      if (c == 2'b01 && a < 9'd256 && !m_valid[a[7:0]]) c = 2'b10;
      if (!allow_err) begin
        if (c == 2'b01 && a >= 9'd256 && a != SW_A) a = SW_A;
        if (c == 2'b10 && a >= 9'd256 && a != LED_A) a = LED_A;
      end else if ($urandom_range(0, 49) == 0) begin
        c = 2'b11;
      end
      step(c, a, d, s);
      check($sformatf("rnd%0d_read_data", i), read_data, m_rd);
      check($sformatf("rnd%0d_leds", i), {8'h00, leds}, {8'h00, m_leds});
      check($sformatf("rnd%0d_err", i), {15'h0, err}, {15'h0, m_err});
      check($sformatf("rnd%0d_busy", i), {15'h0, busy}, 16'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's `mem_cmd`/`mem_addr` bus. This is the other end of the protocol driven by the control FSM: it services MNONE, MREAD and MWRITE.
- Contains the 256x16 data/instruction RAM and a small memory-mapped I/O decode (LED register, switch input).
- Provides registered read data with one-cycle latency, so an MREAD issued in IF1 presents data for `load_ir` in IF2.
- Optional post-reset RAM clear sweep with a busy indication.

Parameters:
- ADDR_W, 9, width of `mem_addr`
- DATA_W, 16, data word width
- RAM_AW, 8, RAM index width (depth 2^RAM_AW = 256)
- LED_ADDR, 9'h100, write address of LED register
- SW_ADDR, 9'h140, read address of switch input

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-low reset (0 = reset)
- mem_cmd  in  2  00 MNONE, 01 MREAD, 10 MWRITE, 11 illegal
- mem_addr  in  ADDR_W  word address
- write_data  in  DATA_W  data for MWRITE
- sw  in  8  switch inputs
- read_data  out  DATA_W  registered read result
- leds  out  8  LED register
- busy  out  1  high while clear sweep runs; commands ignored
- err  out  1  sticky: illegal cmd or unmapped access

Behaviour:
- Reset (reset==0 at posedge):
  - `read_data`=0, `leds`=0, `err`=0.
  - FSM -> CLEAR if MEM_CLEAR_EN is defined, else SERVE; clear pointer=0.
  - RAM contents are not reset by reset itself.
  - Reset asserted mid-sweep or mid-access aborts it; the sweep restarts at index 0.
- Address decode:
  - RAM: `mem_addr[8]`==0, index=`mem_addr[7:0]`.
  - LED: `mem_addr`==LED_ADDR (write only).
  - SW: `mem_addr`==SW_ADDR (read only).
  - Everything else is unmapped.
- FSM states:
  - CLEAR: writes 0 to RAM[ptr] each cycle and increments ptr. At ptr==255 it writes the final location and goes to SERVE next cycle. `busy`=1 for exactly 256 cycles.
  - SERVE: `busy`=0; services one command per cycle. No terminal state.
- MREAD in SERVE, response one cycle later:
  - RAM: `read_data`<=RAM[index] at the posedge sampling the command; valid the following cycle.
  - SW: `read_data`<={8'h00, sw}.
  - LED address or unmapped: `read_data`<=0 and `err`<=1.
- MWRITE in SERVE:
  - RAM: RAM[index]<=`write_data` at posedge.
  - LED: `leds`<=`write_data[7:0]`.
  - SW address or unmapped: no state change, `err`<=1.
  - `read_data` holds.
- MNONE: no change; `read_data` holds its last value.
- cmd 11: no memory or LED change, `read_data` holds, `err`<=1.
- Write-then-read: a read of the same address on the next cycle returns the newly written value. No same-cycle read/write is possible.
- Back-to-back MREADs: each returns its own data one cycle later; full throughput.
- While `busy`: all commands are ignored (no write, `read_data` held at 0, `err` unaffected).
- `err` clears only on reset.
- Index wraps naturally at 8 bits; no out-of-range RAM access exists.

Optional Feature:
- Macro: MEM_CLEAR_EN.
- Defined: after every reset the FSM runs CLEAR (256 cycles, `busy`=1) and the RAM reads all-zero afterwards.
- Undefined: no CLEAR state; SERVE is entered on the first cycle after reset; `busy` is tied to 0; RAM retains contents across reset (preload via init file).

Test Plan:
- MEM_CLEAR_EN defined; write RAM[0x05]=0xBEEF; pulse reset low one cycle -> `busy`=1 for exactly 256 cycles, then MREAD 0x005 returns 0x0000.
- MWRITE 0x012 data 0x1234, next cycle MREAD 0x012 -> `read_data`==0x1234 one cycle after the MREAD; hold with MNONE -> stays 0x1234.
- MWRITE LED_ADDR data 0xFFA5 -> `leds`==0xA5; `sw`=0x3C, MREAD SW_ADDR -> `read_data`==0x003C; `err` stays 0.
- MREAD 0x1FF (unmapped) -> `read_data`==0, `err`==1; later valid accesses work while `err` stays 1 until reset.
- `mem_cmd`=11 with addr 0x010, `write_data` 0x5555 -> RAM[0x10] unchanged, `err`==1; MWRITE during `busy` -> ignored.
- Reset asserted at clear cycle 100 -> sweep restarts; `busy` high for a full 256 cycles after release.
